// File: rtl/core_pkg.sv
// Shared core definitions: datapath widths and load-size encoding used by
// the writeback stage and its load alignment helper.
package core_pkg;

  localparam int unsigned DATA_WIDTH    = 64;
  localparam int unsigned RF_ADDR_WIDTH = 5;
  localparam int unsigned OFFSET_WIDTH  = $clog2(DATA_WIDTH / 8);

  typedef enum logic [1:0] {
    LS_BYTE   = 2'd0,
    LS_HALF   = 2'd1,
    LS_WORD   = 2'd2,
    LS_DOUBLE = 2'd3
  } load_size_e;

endpackage

// File: rtl/writeback_load_align.sv
// Combinational load alignment: shifts the response word down by the byte
// offset, keeps the accessed width and sign- or zero-extends it.
module load_align
  import core_pkg::*;
(
  input  logic [DATA_WIDTH-1:0]   i_rdata,
  input  load_size_e              i_size,
  input  logic                    i_unsigned,
  input  logic [OFFSET_WIDTH-1:0] i_offset,
  output logic [DATA_WIDTH-1:0]   o_data
);

  logic [DATA_WIDTH-1:0] w_shifted;
  logic [DATA_WIDTH-1:0] w_mask;
  logic                  w_sign;

  // Select the kept field and its sign bit; on a 32-bit datapath a double
  // access degenerates to the full word.
  always_comb begin
    w_shifted = i_rdata >> {i_offset, 3'b000};
    w_mask    = {DATA_WIDTH{1'b1}};
    w_sign    = w_shifted[DATA_WIDTH-1];
    case (i_size)
      LS_BYTE: begin
        w_mask = DATA_WIDTH'(8'hFF);
        w_sign = w_shifted[7];
      end
      LS_HALF: begin
        w_mask = DATA_WIDTH'(16'hFFFF);
        w_sign = w_shifted[15];
      end
      LS_WORD: begin
        w_mask = DATA_WIDTH'(32'hFFFF_FFFF);
        w_sign = w_shifted[31];
      end
      LS_DOUBLE: begin
        w_mask = {DATA_WIDTH{1'b1}};
        w_sign = w_shifted[DATA_WIDTH-1];
      end
      default: begin
        w_mask = {DATA_WIDTH{1'b1}};
        w_sign = w_shifted[DATA_WIDTH-1];
      end
    endcase
    if (!i_unsigned && w_sign) begin
      o_data = (w_shifted & w_mask) | ~w_mask;
    end else begin
      o_data = w_shifted & w_mask;
    end
  end

endmodule

// File: rtl/writeback.sv
// Writeback stage: accepts completed instructions, waits for load data and
// drives the register-file write port. Optional macro WB_INSTRET_EN adds a
// 64-bit retired-instruction counter output.
module writeback
  import core_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     exe_valid_i,
  output logic                     exe_ready_o,
  input  logic                     exe_rd_we_i,
  input  logic [RF_ADDR_WIDTH-1:0] exe_rd_i,
  input  logic [DATA_WIDTH-1:0]    exe_result_i,
  input  logic                     exe_is_load_i,
  input  logic [1:0]               exe_load_size_i,
  input  logic                     exe_load_unsigned_i,
  input  logic [OFFSET_WIDTH-1:0]  exe_addr_lsb_i,
  input  logic                     mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]    mem_rdata_i,
  output logic                     wb_valid_o,
  output logic [RF_ADDR_WIDTH-1:0] rd_o,
  output logic [DATA_WIDTH-1:0]    rd_data_o
`ifdef WB_INSTRET_EN
  ,
  output logic [63:0]              wb_instret_o
`endif
);

  typedef enum logic [0:0] {
    WB_IDLE     = 1'b0,
    WB_WAIT_MEM = 1'b1
  } wb_state_e;

  wb_state_e                r_state;
  logic [RF_ADDR_WIDTH-1:0] r_rd;
  logic                     r_rd_we;
  load_size_e               r_size;
  logic                     r_unsigned;
  logic [OFFSET_WIDTH-1:0]  r_offset;

  logic                     w_accept;
  logic                     w_resp;
  logic [DATA_WIDTH-1:0]    w_aligned;

  load_align u_load_align (
    .i_rdata    (mem_rdata_i),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .i_offset   (r_offset),
    .o_data     (w_aligned)
  );

  assign exe_ready_o = (r_state == WB_IDLE);

  // Handshake decode; a response outside WAIT_MEM is simply ignored.
  always_comb begin
    w_accept = exe_valid_i && (r_state == WB_IDLE);
    w_resp   = mem_rvalid_i && (r_state == WB_WAIT_MEM);
  end

  // State machine, latched load context and registered write port.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= WB_IDLE;
      r_rd       <= {RF_ADDR_WIDTH{1'b0}};
      r_rd_we    <= 1'b0;
      r_size     <= LS_BYTE;
      r_unsigned <= 1'b0;
      r_offset   <= {OFFSET_WIDTH{1'b0}};
      wb_valid_o <= 1'b0;
      rd_o       <= {RF_ADDR_WIDTH{1'b0}};
      rd_data_o  <= {DATA_WIDTH{1'b0}};
    end else begin
      wb_valid_o <= 1'b0;
      case (r_state)
        WB_IDLE: begin
          if (w_accept) begin
            r_rd       <= exe_rd_i;
            r_rd_we    <= exe_rd_we_i;
            r_size     <= load_size_e'(exe_load_size_i);
            r_unsigned <= exe_load_unsigned_i;
            r_offset   <= exe_addr_lsb_i;
            if (exe_is_load_i) begin
              r_state <= WB_WAIT_MEM;
            end else if (exe_rd_we_i && (exe_rd_i != {RF_ADDR_WIDTH{1'b0}})) begin
              // rd_o/rd_data_o only move on a real write so they hold otherwise.
              wb_valid_o <= 1'b1;
              rd_o       <= exe_rd_i;
              rd_data_o  <= exe_result_i;
            end
          end
        end
        WB_WAIT_MEM: begin
          if (w_resp) begin
            r_state <= WB_IDLE;
            if (r_rd_we && (r_rd != {RF_ADDR_WIDTH{1'b0}})) begin
              wb_valid_o <= 1'b1;
              rd_o       <= r_rd;
              rd_data_o  <= w_aligned;
            end
          end
        end
        default: begin
          r_state <= WB_IDLE;
        end
      endcase
    end
  end

`ifdef WB_INSTRET_EN
  logic w_retire;

  // Every completed instruction retires, including suppressed writes.
  always_comb begin
    w_retire = (w_accept && !exe_is_load_i) || w_resp;
  end

  // Free-running retire counter; wraps naturally at 2^64.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb_instret_o <= 64'd0;
    end else if (w_retire) begin
      wb_instret_o <= wb_instret_o + 64'd1;
    end else begin
      wb_instret_o <= wb_instret_o;
    end
  end
`endif

endmodule

// File: tb/tb_writeback.sv
// Self-checking bench for writeback: a vector table of non-load and load
// transactions feeds a timestamped scoreboard, plus hand-written corner cases.
module tb_writeback;
  import core_pkg::*;

  logic                     clk_i = 1'b0;
  logic                     rst_i = 1'b1;
  logic                     exe_valid_i = 1'b0;
  logic                     exe_ready_o;
  logic                     exe_rd_we_i = 1'b0;
  logic [RF_ADDR_WIDTH-1:0] exe_rd_i = '0;
  logic [DATA_WIDTH-1:0]    exe_result_i = '0;
  logic                     exe_is_load_i = 1'b0;
  logic [1:0]               exe_load_size_i = 2'd0;
  logic                     exe_load_unsigned_i = 1'b0;
  logic [OFFSET_WIDTH-1:0]  exe_addr_lsb_i = '0;
  logic                     mem_rvalid_i = 1'b0;
  logic [DATA_WIDTH-1:0]    mem_rdata_i = '0;
  logic                     wb_valid_o;
  logic [RF_ADDR_WIDTH-1:0] rd_o;
  logic [DATA_WIDTH-1:0]    rd_data_o;
`ifdef WB_INSTRET_EN
  logic [63:0]              wb_instret_o;
`endif

  writeback dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .exe_valid_i         (exe_valid_i),
    .exe_ready_o         (exe_ready_o),
    .exe_rd_we_i         (exe_rd_we_i),
    .exe_rd_i            (exe_rd_i),
    .exe_result_i        (exe_result_i),
    .exe_is_load_i       (exe_is_load_i),
    .exe_load_size_i     (exe_load_size_i),
    .exe_load_unsigned_i (exe_load_unsigned_i),
    .exe_addr_lsb_i      (exe_addr_lsb_i),
    .mem_rvalid_i        (mem_rvalid_i),
    .mem_rdata_i         (mem_rdata_i),
    .wb_valid_o          (wb_valid_o),
    .rd_o                (rd_o),
    .rd_data_o           (rd_data_o)
`ifdef WB_INSTRET_EN
    ,
    .wb_instret_o        (wb_instret_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    int                       exp_cyc;
    logic [RF_ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0]    data;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic                     is_load;
    logic [1:0]               size;
    logic                     uns;
    logic [OFFSET_WIDTH-1:0]  off;
    logic [RF_ADDR_WIDTH-1:0] rd;
    logic                     we;
    logic [DATA_WIDTH-1:0]    result;
    logic [DATA_WIDTH-1:0]    rdata;
    int                       delay;
    logic [DATA_WIDTH-1:0]    exp;
  } vec_t;
  vec_t vecs[13];

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    sb_t e;
    forever begin
      @(posedge clk_i);
      #1;
      while (sb_q.size() > 0 && sb_q[0].exp_cyc < cyc) begin
        e = sb_q.pop_front();
        check("missing_write", 64'(wb_valid_o), 64'd1);
      end
      if (wb_valid_o === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("unexpected_write", 64'(rd_data_o), 64'hDEAD_DEAD_DEAD_DEAD);
        end else begin
          e = sb_q.pop_front();
          check("write_cycle", 64'(cyc), 64'(e.exp_cyc));
          check("write_rd", 64'(rd_o), 64'(e.rd));
          check("write_data", rd_data_o, e.data);
        end
      end
    end
  end

  task automatic push(input logic [RF_ADDR_WIDTH-1:0] rd, input logic [DATA_WIDTH-1:0] data);
    sb_t e;
    e.exp_cyc = cyc + 1;
    e.rd      = rd;
    e.data    = data;
    sb_q.push_back(e);
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk_i);
    exe_valid_i         = 1'b1;
    exe_is_load_i       = v.is_load;
    exe_load_size_i     = v.size;
    exe_load_unsigned_i = v.uns;
    exe_addr_lsb_i      = v.off;
    exe_rd_i            = v.rd;
    exe_rd_we_i         = v.we;
    exe_result_i        = v.result;
    if (!v.is_load && v.we && v.rd != '0) push(v.rd, v.result);
    @(negedge clk_i);
    exe_valid_i = 1'b0;
    if (v.is_load) begin
      check("ready_low_wait", 64'(exe_ready_o), 64'd0);
      repeat (v.delay - 1) @(negedge clk_i);
      check("ready_low_pre_resp", 64'(exe_ready_o), 64'd0);
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = v.rdata;
      if (v.we && v.rd != '0) push(v.rd, v.exp);
      @(negedge clk_i);
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      check("ready_after_resp", 64'(exe_ready_o), 64'd1);
    end
  endtask

  function automatic vec_t mk(input logic ld, input logic [1:0] sz, input logic u,
                              input int off, input int rd, input logic we,
                              input logic [63:0] res, input logic [63:0] rdat,
                              input int dly, input logic [63:0] exp);
    vec_t v;
    v.is_load = ld; v.size = sz; v.uns = u; v.off = OFFSET_WIDTH'(off);
    v.rd = RF_ADDR_WIDTH'(rd); v.we = we; v.result = res; v.rdata = rdat;
    v.delay = dly; v.exp = exp;
    return v;
  endfunction

  initial begin
    vecs[0]  = mk(1'b0, 2'd0, 1'b0, 0, 5,  1'b1, 64'h1234, 64'h0, 1, 64'h1234);
    vecs[1]  = mk(1'b0, 2'd0, 1'b0, 0, 0,  1'b1, 64'h5555, 64'h0, 1, 64'h0);
    vecs[2]  = mk(1'b1, 2'd0, 1'b0, 3, 10, 1'b1, 64'h0, 64'h0000_0000_80FF_0000, 2, 64'hFFFF_FFFF_FFFF_FF80);
    vecs[3]  = mk(1'b1, 2'd0, 1'b1, 3, 11, 1'b1, 64'h0, 64'h0000_0000_80FF_0000, 2, 64'h80);
    vecs[4]  = mk(1'b1, 2'd1, 1'b0, 2, 12, 1'b1, 64'h0, 64'h7FFF_0000, 1, 64'h7FFF);
    vecs[5]  = mk(1'b1, 2'd2, 1'b1, 4, 13, 1'b1, 64'h0, 64'hDEAD_BEEF_0000_0000, 3, 64'hDEAD_BEEF);
    vecs[6]  = mk(1'b1, 2'd2, 1'b0, 4, 14, 1'b1, 64'h0, 64'hDEAD_BEEF_0000_0000, 1, 64'hFFFF_FFFF_DEAD_BEEF);
    vecs[7]  = mk(1'b1, 2'd3, 1'b0, 0, 15, 1'b1, 64'h0, 64'h0123_4567_89AB_CDEF, 1, 64'h0123_4567_89AB_CDEF);
    vecs[8]  = mk(1'b0, 2'd0, 1'b0, 0, 7,  1'b0, 64'h9999, 64'h0, 1, 64'h0);
    vecs[9]  = mk(1'b1, 2'd1, 1'b1, 6, 31, 1'b1, 64'h0, 64'hBEEF_0000_0000_0000, 1, 64'hBEEF);
    vecs[10] = mk(1'b1, 2'd0, 1'b0, 7, 1,  1'b1, 64'h0, 64'h7F00_0000_0000_0000, 2, 64'h7F);
    vecs[11] = mk(1'b1, 2'd1, 1'b0, 7, 2,  1'b1, 64'h0, 64'hAB00_0000_0000_0000, 1, 64'hAB);
    vecs[12] = mk(1'b1, 2'd2, 1'b0, 0, 3,  1'b0, 64'h0, 64'hFFFF_FFFF, 1, 64'h0);

    // Reset held for two cycles.
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    check("rst_ready", 64'(exe_ready_o), 64'd1);
    check("rst_valid", 64'(wb_valid_o), 64'd0);
    check("rst_rd", 64'(rd_o), 64'd0);
    check("rst_data", rd_data_o, 64'd0);
`ifdef WB_INSTRET_EN
    check("rst_instret", wb_instret_o, 64'd0);
`endif
    rst_i = 1'b0;

    // Back-to-back non-loads: rd=5 commits, then rd=0 retires silently.
    @(negedge clk_i);
    exe_valid_i = 1'b1; exe_is_load_i = 1'b0; exe_rd_we_i = 1'b1;
    exe_rd_i = 5'd5; exe_result_i = 64'h1234;
    push(5'd5, 64'h1234);
    @(negedge clk_i);
    check("b2b_c1_valid", 64'(wb_valid_o), 64'd1);
    exe_rd_i = 5'd0; exe_result_i = 64'hFFFF;
    @(negedge clk_i);
    exe_valid_i = 1'b0;
    check("b2b_c2_valid", 64'(wb_valid_o), 64'd0);
    check("b2b_c2_rd_hold", 64'(rd_o), 64'd5);
    check("b2b_c2_data_hold", rd_data_o, 64'h1234);
`ifdef WB_INSTRET_EN
    check("b2b_instret", wb_instret_o, 64'd2);
`endif

    foreach (vecs[i]) run_vec(vecs[i]);

    // Response pulse while idle must not write.
    @(negedge clk_i);
    mem_rvalid_i = 1'b1; mem_rdata_i = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk_i);
    mem_rvalid_i = 1'b0;
    check("idle_rvalid_no_write", 64'(wb_valid_o), 64'd0);

    // Reset while waiting abandons the load; the late response is ignored.
    @(negedge clk_i);
    exe_valid_i = 1'b1; exe_is_load_i = 1'b1; exe_rd_we_i = 1'b1;
    exe_rd_i = 5'd9; exe_load_size_i = 2'd3;
    @(negedge clk_i);
    exe_valid_i = 1'b0;
    check("midload_ready_low", 64'(exe_ready_o), 64'd0);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check("midload_rst_ready", 64'(exe_ready_o), 64'd1);
    check("midload_rst_rd", 64'(rd_o), 64'd0);
    check("midload_rst_data", rd_data_o, 64'd0);
    mem_rvalid_i = 1'b1; mem_rdata_i = 64'h1111_2222_3333_4444;
    @(negedge clk_i);
    mem_rvalid_i = 1'b0;
    check("late_resp_no_write", 64'(wb_valid_o), 64'd0);
    check("late_resp_ready", 64'(exe_ready_o), 64'd1);

`ifdef WB_INSTRET_EN
    @(negedge clk_i);
    force dut.wb_instret_o = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.wb_instret_o;
    exe_valid_i = 1'b1; exe_is_load_i = 1'b0; exe_rd_we_i = 1'b0; exe_rd_i = 5'd4;
    @(negedge clk_i);
    exe_valid_i = 1'b0;
    check("instret_wrap", wb_instret_o, 64'd0);
`endif

    repeat (4) @(negedge clk_i);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
